wb_data_ram: RTL and testbench
==============================

# wb_data_ram

Single-port Wishbone B4 responder RAM for the CPU data bus: it sits behind the core's `dBusWishbone_*` initiator port and returns read data, byte-lane writes and bus errors. It supports classic single transfers and incrementing linear bursts (CTI/BTE), with zero-wait beats once a burst is running. Memory contents are word-organised, optionally preloaded from a hex image, and not cleared by reset.

## Interface
- `ADDR_WIDTH`, 10, word-address bits; capacity is 2^ADDR_WIDTH 32-bit words (default 4 KiB).
- `INIT_FILE`, "", `$readmemh` image loaded at elaboration; an empty string means no preload (contents undefined).
- `clk  in  1`  sole clock; all logic is on the rising edge.
- `reset_n  in  1`  asynchronous, active-low reset; release is synchronous to `clk` upstream.
- `wbs_cyc_i  in  1`  bus cycle valid.
- `wbs_stb_i  in  1`  strobe.
- `wbs_we_i  in  1`  1 = write.
- `wbs_adr_i  in  32`  byte address; bits [1:0] are ignored, and word index = adr[31:2].
- `wbs_dat_i  in  32`  write data.
- `wbs_sel_i  in  4`  byte-lane enables; bit i writes byte [8i+7:8i].
- `wbs_cti_i  in  3`  cycle type: 000 classic, 010 incrementing burst, 111 end-of-burst; any other value is treated as 000.
- `wbs_bte_i  in  2`  burst type; only 00 (linear) bursts.
- `wbs_dat_o  out  32`  read data; valid when `wbs_ack_o` = 1.
- `wbs_ack_o  out  1`  registered acknowledge.
- `wbs_err_o  out  1`  registered error, mutually exclusive with `wbs_ack_o`.

## Operation
- Request (req) = `cyc & stb`. In range = adr[31:ADDR_WIDTH+2] == 0.
- States:
  - IDLE
    - IDLE → RESP on req.
  - RESP (single ack/err beat)
    - RESP → IDLE unless the burst condition holds.
    - Burst condition: CTI=010, BTE=00, req still high and beat in range. It sends RESP → BURST.
  - BURST (ack every cycle)
    - BURST → IDLE when req drops, when the acked beat has CTI≠010, or when the next prefetch address is out of range.
- On entry to RESP, the edge that sees req in IDLE:
  - In range: register `dat_o` = mem[adr[ADDR_WIDTH+1:2]] and set ack = 1.
  - Out of range: set err = 1 and `dat_o` = 0.
- Writes commit at a rising edge where `ack_o & cyc & stb & we`, using the current `adr`/`dat_i`/`sel`. Only lanes with `sel`=1 change; `sel`=0000 is acked but writes nothing. Error beats never write.
- Burst prefetch:
  - An internal word counter `nxt` = beat address + 1.
  - In each cycle with ack = 1 and burst condition true, `dat_o` loads mem[`nxt`] at the edge and `nxt` increments.
  - A read-prefetch of a word being written in the same beat is impossible: the counter is always ahead.
- Burst reaching the top word: the following beat gets err = 1 (not ack), and the FSM returns to IDLE.
- `we` may not change within a burst. If it does, behaviour is defined only as "no write outside acked beats".
- CTI=010 with BTE≠00 runs as a classic transfer: one ack, then IDLE.

## Timing
- Reset (async assert): `wbs_ack_o`=0, `wbs_err_o`=0, `wbs_dat_o`=0, state IDLE, `nxt`=0. Memory is untouched. Reset mid-burst aborts the burst; no write occurs at the reset edge.
- Classic cycles:
  - req sampled at edge N gives ack/err high in cycle N+1 (1 wait state). ack then low in N+2 regardless of req.
  - A new classic request held high is sampled at N+2 and acked in N+3: 2 cycles per transfer.
- Bursts:
  - The first beat is acked in cycle N+1, and subsequent beats in N+2, N+3, … with no gaps.
  - ack falls the cycle after the CTI=111 beat is acked.
- Master drops `stb` or `cyc` while ack is high: ack goes low the next cycle, and the FSM returns to IDLE. The next req is treated as a new access with 1 wait state.
- `dat_o` holds its last value when ack=0; it is cleared only on reset or on an error beat.

## Test plan
- Reset then classic read of word 5 (preloaded 0xDEADBEEF), req in cycle N → ack only in N+1 with `dat_o`=0xDEADBEEF; ack=0 in N+2.
- Classic write 0x11223344 with sel=0101 to a word holding 0xAABBCCDD, then read back → 0xAA22CC44; sel=0000 write → ack, word unchanged.
- 4-beat linear burst read from word 8 (CTI 010,010,010,111) → ack high for 4 consecutive cycles starting N+1, data mem[8..11]; ack low on the 5th cycle.
- Burst write of 4 words followed by a classic readback of each → all four values match, and the neighbouring words are unchanged.
- Address 0x0000_1000 with ADDR_WIDTH=10 → err=1 in N+1, ack=0, `dat_o`=0, memory unchanged. A burst starting at word 1022 → ack beats 1022 and 1023, then err on the third beat.
- Assert `reset_n`=0 mid-burst (ack high) → ack/err/`dat_o` go 0 immediately. After release, a classic read returns previously written data, proving memory is retained.

Source files
------------

// File: rtl/wb_data_ram.sv
// ============================================================================
// Module   : wb_data_ram
// Brief    : Wishbone B4 responder RAM with classic and linear-burst beats.
// Revision : 1.0
// ============================================================================
`default_nettype none

module wb_data_ram #(
    parameter int    ADDR_WIDTH = 10,
    parameter string INIT_FILE  = ""
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [2:0]  wbs_cti_i,
    input  logic [1:0]  wbs_bte_i,
    output logic [31:0] wbs_dat_o,
    output logic        wbs_ack_o,
    output logic        wbs_err_o
);

    localparam int c_DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RESP  = 2'd1,
        ST_BURST = 2'd2
    } state_t;

    logic [31:0]         r_mem [0:c_DEPTH-1];
    state_t              r_state, w_state_nxt;
    logic                r_ack, w_ack_nxt;
    logic                r_err, w_err_nxt;
    logic [31:0]         r_dat, w_dat_nxt;
    logic [ADDR_WIDTH:0] r_nxt, w_nxt_nxt;

    logic                  w_req, w_in_range, w_burst;
    logic [ADDR_WIDTH-1:0] w_word, w_rd_addr;
    logic [31:0]           w_rd_data;
    logic                  w_unused_bits;

    assign w_req         = wbs_cyc_i & wbs_stb_i;
    assign w_in_range    = (wbs_adr_i[31:ADDR_WIDTH+2] == '0);
    assign w_word        = wbs_adr_i[ADDR_WIDTH+1:2];
    assign w_burst       = w_req & w_in_range & (wbs_cti_i == 3'b010) & (wbs_bte_i == 2'b00);
    assign w_unused_bits = ^wbs_adr_i[1:0];

    // IDLE reads the requested word; afterwards reads follow the prefetch counter.
    assign w_rd_addr = (r_state == ST_IDLE) ? w_word : r_nxt[ADDR_WIDTH-1:0];
    assign w_rd_data = r_mem[w_rd_addr];

    always_comb begin
        w_state_nxt = r_state;
        w_ack_nxt   = 1'b0;
        w_err_nxt   = 1'b0;
        w_dat_nxt   = r_dat;
        w_nxt_nxt   = r_nxt;
        case (r_state)
            ST_IDLE: begin
                if (w_req) begin
                    w_state_nxt = ST_RESP;
                    if (w_in_range) begin
                        w_ack_nxt = 1'b1;
                        w_dat_nxt = w_rd_data;
                        w_nxt_nxt = {1'b0, w_word} + 1'b1;
                    end else begin
                        w_err_nxt = 1'b1;
                        w_dat_nxt = '0;
                    end
                end
            end
            ST_RESP, ST_BURST: begin
                if (r_ack && w_burst) begin
                    // Counter carried past the top word: answer the next beat with err.
                    if (r_nxt[ADDR_WIDTH]) begin
                        w_state_nxt = ST_RESP;
                        w_err_nxt   = 1'b1;
                        w_dat_nxt   = '0;
                    end else begin
                        w_state_nxt = ST_BURST;
                        w_ack_nxt   = 1'b1;
                        w_dat_nxt   = w_rd_data;
                        w_nxt_nxt   = r_nxt + 1'b1;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_dat   <= '0;
            r_nxt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ack   <= w_ack_nxt;
            r_err   <= w_err_nxt;
            r_dat   <= w_dat_nxt;
            r_nxt   <= w_nxt_nxt;
        end
    end

    // Memory has no reset; a write needs an acked beat, so reset blocks it at once.
    always_ff @(posedge clk) begin
        if (r_ack && w_req && wbs_we_i && w_in_range) begin
            for (int i = 0; i < 4; i++) begin
                if (wbs_sel_i[i]) begin
                    r_mem[w_word][8*i +: 8] <= wbs_dat_i[8*i +: 8];
                end
            end
        end
    end

    assign wbs_dat_o = r_dat;
    assign wbs_ack_o = r_ack;
    assign wbs_err_o = r_err;

endmodule

`default_nettype wire

// File: tb/tb_wb_data_ram.sv
// ============================================================================
// Module   : tb_wb_data_ram
// Brief    : Directed/random bench for wb_data_ram against a word-array model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_wb_data_ram;

    localparam int WORDS = 1024;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cyc, stb, we;
    logic [31:0] adr, dat_i;
    logic [3:0]  sel;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic [31:0] dat_o;
    logic        ack, err;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] model [0:WORDS-1];

    wb_data_ram #(.ADDR_WIDTH(10), .INIT_FILE("")) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .wbs_cyc_i (cyc),
        .wbs_stb_i (stb),
        .wbs_we_i  (we),
        .wbs_adr_i (adr),
        .wbs_dat_i (dat_i),
        .wbs_sel_i (sel),
        .wbs_cti_i (cti),
        .wbs_bte_i (bte),
        .wbs_dat_o (dat_o),
        .wbs_ack_o (ack),
        .wbs_err_o (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = nw[8*i +: 8];
        return r;
    endfunction

    task automatic drive(input logic rq, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s,
                         input logic [2:0] c, input logic [1:0] b);
        cyc = rq; stb = rq; we = w; adr = a; dat_i = d; sel = s; cti = c; bte = b;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 3'b000, 2'b00);
    endtask

    // One transfer with 1 wait state; req is dropped right after the response edge.
    task automatic classic(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, input logic [2:0] c, input logic [1:0] b);
        logic oor;
        int   idx;
        oor = (a >= 32'(WORDS * 4));
        idx = int'(a[11:2]);
        @(posedge clk); #1;
        drive(1'b1, w, a, d, s, c, b);
        @(negedge clk);
        check("cls_wait_ack", ack, 1'b0);
        @(posedge clk);
        @(negedge clk);
        check("cls_ack", ack, !oor);
        check("cls_err", err, oor);
        if (oor) check("cls_err_dat", dat_o, 32'h0);
        else if (!w) check("cls_rdat", dat_o, model[idx]);
        @(posedge clk); #1;
        if (w && !oor) model[idx] = merge(model[idx], d, s);
        idle();
        @(negedge clk);
        check("cls_ack_drop", ack, 1'b0);
        check("cls_err_drop", err, 1'b0);
    endtask

    // Incrementing linear burst of n beats; beats past the top word expect err.
    task automatic burst(input logic w, input int start, input int n);
        logic [31:0] d;
        logic [3:0]  s;
        logic        done;
        int          word;
        done = 1'b0;
        @(posedge clk); #1;
        d = $urandom; s = 4'($urandom);
        drive(1'b1, w, 32'(start * 4), d, s, (n == 1) ? 3'b111 : 3'b010, 2'b00);
        @(negedge clk);
        check("bst_wait_ack", ack, 1'b0);
        @(posedge clk);
        for (int k = 0; k < n && !done; k++) begin
            word = start + k;
            @(negedge clk);
            if (word >= WORDS) begin
                check("bst_top_err", err, 1'b1);
                check("bst_top_ack", ack, 1'b0);
                check("bst_top_dat", dat_o, 32'h0);
                done = 1'b1;
            end else begin
                check("bst_ack", ack, 1'b1);
                check("bst_err", err, 1'b0);
                if (!w) check("bst_rdat", dat_o, model[word]);
            end
            @(posedge clk); #1;
            if (!done && w) model[word] = merge(model[word], d, s);
            if (!done && k + 1 < n) begin
                d = $urandom; s = 4'($urandom);
                drive(1'b1, w, 32'((word + 1) * 4), d, s,
                      (k + 2 == n) ? 3'b111 : 3'b010, 2'b00);
            end else begin
                idle();
            end
        end
        @(negedge clk);
        check("bst_ack_end", ack, 1'b0);
        check("bst_err_end", err, 1'b0);
    endtask

    initial begin
        int          st;
        logic [31:0] d;
        reset_n = 1'b0;
        idle();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ack", ack, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_dat", dat_o, 32'h0);
        @(posedge clk); #1;
        reset_n = 1'b1;

        // Give every word the bench later reads a known value.
        for (int i = 0; i < 32; i++) classic(1'b1, 32'(i * 4), $urandom, 4'hF, 3'b000, 2'b00);
        for (int i = 1016; i < 1024; i++) classic(1'b1, 32'(i * 4), $urandom, 4'hF, 3'b000, 2'b00);

        classic(1'b1, 32'h14, 32'hDEADBEEF, 4'hF, 3'b000, 2'b00);
        classic(1'b0, 32'h14, 32'h0, 4'h0, 3'b000, 2'b00);
        check("word5_const", model[5], 32'hDEADBEEF);

        classic(1'b1, 32'h18, 32'hAABBCCDD, 4'hF, 3'b000, 2'b00);
        classic(1'b1, 32'h18, 32'h11223344, 4'b0101, 3'b000, 2'b00);
        classic(1'b0, 32'h18, 32'h0, 4'h0, 3'b000, 2'b00);
        check("lane_merge_const", model[6], 32'hAA22CC44);
        classic(1'b1, 32'h18, 32'hFFFFFFFF, 4'b0000, 3'b000, 2'b00);
        classic(1'b0, 32'h18, 32'h0, 4'h0, 3'b000, 2'b00);

        // Held request: transfers every other cycle.
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 32'h14, 32'h0, 4'h0, 3'b000, 2'b00);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("held_ack", ack, (c == 1 || c == 3));
            if (c == 1 || c == 3) check("held_dat", dat_o, model[5]);
            @(posedge clk);
        end
        #1 idle();
        @(negedge clk);
        check("held_ack_end", ack, 1'b0);

        // CTI=010 with non-linear BTE is a single classic beat.
        classic(1'b0, 32'h24, 32'h0, 4'h0, 3'b010, 2'b01);

        for (int i = 0; i < 20; i++)
            classic(1'($urandom), 32'($urandom_range(0, 31) * 4), $urandom, 4'($urandom),
                    3'b000, 2'b00);

        burst(1'b0, 8, 4);

        st = $urandom_range(12, 20);
        burst(1'b1, st, 4);
        for (int i = -1; i < 5; i++) classic(1'b0, 32'((st + i) * 4), 32'h0, 4'h0, 3'b000, 2'b00);

        classic(1'b1, 32'h0000_1000, 32'h12345678, 4'hF, 3'b000, 2'b00);
        classic(1'b0, 32'h0000_1000, 32'h0, 4'h0, 3'b000, 2'b00);
        classic(1'b0, 32'h0, 32'h0, 4'h0, 3'b000, 2'b00);

        burst(1'b0, 1022, 4);
        burst(1'b1, 1023, 2);
        classic(1'b0, 32'(1023 * 4), 32'h0, 4'h0, 3'b000, 2'b00);

        for (int i = 0; i < 6; i++)
            burst(1'($urandom), $urandom_range(0, 27), $urandom_range(1, 4));

        // Reset while the third beat of a write burst is acked: that beat must not commit.
        @(posedge clk); #1;
        d = $urandom;
        drive(1'b1, 1'b1, 32'(24 * 4), d, 4'hF, 3'b010, 2'b00);
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("rstb_ack", ack, 1'b1);
            @(posedge clk); #1;
            model[24 + k] = d;
            d = $urandom;
            drive(1'b1, 1'b1, 32'((25 + k) * 4), d, 4'hF, 3'b010, 2'b00);
        end
        @(negedge clk);
        check("rstb_ack_pre", ack, 1'b1);
        reset_n = 1'b0;
        #1;
        check("rstb_ack0", ack, 1'b0);
        check("rstb_err0", err, 1'b0);
        check("rstb_dat0", dat_o, 32'h0);
        @(posedge clk); #1;
        idle();
        @(posedge clk); #1;
        reset_n = 1'b1;
        for (int i = 24; i < 28; i++) classic(1'b0, 32'(i * 4), 32'h0, 4'h0, 3'b000, 2'b00);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
